// File: rtl/palette_player_attack_encoder.sv
// ---------------------------------------------------------------------------
// palette_player_attack_encoder
//
// Converts a 24-bit RGB pixel into the 4-bit index of the nearest entry in
// the fixed player-attack palette. This is the reverse of the palette lookup.
// The sprite-capture/recolour path uses it to re-encode pixels into the
// sprite ROM index format.
//
// The search is sequential and evaluates one palette entry per clock. The
// distance metric is the Manhattan distance |dR|+|dG|+|dB|. Its maximum is
// 765, so it fits in 10 bits without overflow. When two entries are equally
// close, the lower index wins. With EARLY_EXIT=1 the search stops at the
// first exact match.
//
// Parameters:
//   NUM_ENTRIES  number of palette entries searched (1..7)
//   EARLY_EXIT   1: finish the search as soon as the distance is zero
//
// Ports:
//   Clk        system clock, rising edge
//   Reset      asynchronous, active-high reset
//   in_valid   in_rgb holds a pixel
//   in_ready   encoder can accept a pixel (high only while idle)
//   in_rgb     pixel, [23:16]=R, [15:8]=G, [7:0]=B
//   out_valid  result is available (high only in DONE)
//   out_ready  consumer accepts the result
//   out_index  nearest palette index
//   out_dist   distance from the pixel to the chosen entry
// ---------------------------------------------------------------------------
module palette_player_attack_encoder #(
    parameter int NUM_ENTRIES = 7,
    parameter bit EARLY_EXIT  = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_rgb,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_index,
    output logic [9:0]  out_dist
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [2:0] LAST_PTR = 3'(NUM_ENTRIES - 1);

    // Fixed player-attack palette. It must stay in step with the forward
    // lookup ROM.
    function automatic logic [23:0] palette_entry(input logic [2:0] idx);
        logic [23:0] rgb;
        case (idx)
            3'd0:    rgb = 24'hFF4295;
            3'd1:    rgb = 24'h321A07;
            3'd2:    rgb = 24'hC7AB62;
            3'd3:    rgb = 24'hAE3F00;
            3'd4:    rgb = 24'h756332;
            3'd5:    rgb = 24'hF6F2CF;
            3'd6:    rgb = 24'hA08548;
            default: rgb = 24'h000000;
        endcase
        return rgb;
    endfunction

    // |a-b| of two 8-bit channels. Both operands are widened to a signed
    // 10-bit value, so the difference cannot wrap.
    function automatic logic [9:0] chan_absdiff(input logic [7:0] a,
                                                input logic [7:0] b);
        logic signed [9:0] diff;
        logic signed [9:0] mag;
        diff = signed'({2'b00, a}) - signed'({2'b00, b});
        mag  = (diff < 0) ? -diff : diff;
        return unsigned'(mag);
    endfunction

    // Manhattan distance between two RGB888 pixels. The worst case is
    // 3*255 = 765.
    function automatic logic [9:0] rgb_dist(input logic [23:0] p,
                                            input logic [23:0] q);
        return chan_absdiff(p[23:16], q[23:16])
             + chan_absdiff(p[15:8],  q[15:8])
             + chan_absdiff(p[7:0],   q[7:0]);
    endfunction

    logic [1:0]  state;
    logic [23:0] pix_p0;      // pixel latched at accept
    logic [2:0]  ptr;         // entry evaluated on the next edge
    logic [9:0]  best_dist;
    logic [3:0]  best_idx;

    logic [9:0]  cand_dist;
    logic        cand_better;
    logic [9:0]  nxt_dist;
    logic [3:0]  nxt_idx;
    logic        search_last;

    // Search stage: compare the latched pixel against entry ptr.
    always_comb begin
        cand_dist   = rgb_dist(pix_p0, palette_entry(ptr));
        // Strict compare keeps the earlier (lower) index on a tie.
        cand_better = (cand_dist < best_dist);
        nxt_dist    = cand_better ? cand_dist : best_dist;
        nxt_idx     = cand_better ? {1'b0, ptr} : best_idx;
        search_last = (ptr == LAST_PTR) || (EARLY_EXIT && (cand_dist == 10'd0));
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IDLE;
            pix_p0    <= '0;
            ptr       <= '0;
            best_dist <= '0;
            best_idx  <= '0;
            out_index <= '0;
            out_dist  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        pix_p0    <= in_rgb;
                        ptr       <= '0;
                        best_dist <= 10'h3FF;
                        best_idx  <= '0;
                        state     <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    best_dist <= nxt_dist;
                    best_idx  <= nxt_idx;
                    if (search_last) begin
                        // The result includes the entry judged on this edge.
                        out_index <= nxt_idx;
                        out_dist  <= nxt_dist;
                        state     <= ST_DONE;
                    end else begin
                        ptr <= ptr + 3'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_palette_player_attack_encoder.sv
module tb_palette_player_attack_encoder;

    logic        Clk;
    logic        Reset;
    logic        iv   [3];
    logic        ir   [3];
    logic [23:0] rgb  [3];
    logic        ov   [3];
    logic        ordy [3];
    logic [3:0]  oi   [3];
    logic [9:0]  od   [3];

    int checks   = 0;
    int failures = 0;

    // 0: default build, 1: no early exit, 2: only entries 0..2 searched
    palette_player_attack_encoder #(.NUM_ENTRIES(7), .EARLY_EXIT(1'b1)) u_dut0 (
        .Clk(Clk), .Reset(Reset), .in_valid(iv[0]), .in_ready(ir[0]), .in_rgb(rgb[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_index(oi[0]), .out_dist(od[0]));
    palette_player_attack_encoder #(.NUM_ENTRIES(7), .EARLY_EXIT(1'b0)) u_dut1 (
        .Clk(Clk), .Reset(Reset), .in_valid(iv[1]), .in_ready(ir[1]), .in_rgb(rgb[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_index(oi[1]), .out_dist(od[1]));
    palette_player_attack_encoder #(.NUM_ENTRIES(3), .EARLY_EXIT(1'b1)) u_dut2 (
        .Clk(Clk), .Reset(Reset), .in_valid(iv[2]), .in_ready(ir[2]), .in_rgb(rgb[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_index(oi[2]), .out_dist(od[2]));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int          sel;
        logic [23:0] px;
        logic [3:0]  exp_idx;
        logic [9:0]  exp_dist;
        int          exp_lat;
        string       tag;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Full transaction: accept, wait for result, check it, hand it off.
    task automatic run_vec(input vec_t v);
        int lat;
        int s;
        s = v.sel;
        @(negedge Clk);
        chk({v.tag, "_in_ready"}, 32'(ir[s]), 32'd1);
        iv[s]  = 1'b1;
        rgb[s] = v.px;
        @(posedge Clk);
        #1;
        iv[s] = 1'b0;
        lat = 0;
        while (!ov[s] && lat < 50) begin
            @(posedge Clk);
            #1;
            lat++;
        end
        chk({v.tag, "_out_valid"}, 32'(ov[s]), 32'd1);
        chk({v.tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
        chk({v.tag, "_index"}, 32'(oi[s]), 32'(v.exp_idx));
        chk({v.tag, "_dist"}, 32'(od[s]), 32'(v.exp_dist));
        @(negedge Clk);
        ordy[s] = 1'b1;
        @(posedge Clk);
        #1;
        ordy[s] = 1'b0;
        chk({v.tag, "_valid_drop"}, 32'(ov[s]), 32'd0);
        chk({v.tag, "_ready_back"}, 32'(ir[s]), 32'd1);
    endtask

    initial begin
        bit seen_valid;
        vec_t fin;

        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; rgb[i] = '0; ordy[i] = 1'b0;
        end

        vecs[0]  = '{0, 24'hFF4295, 4'd0, 10'd0,   1, "exact0_early"};
        vecs[1]  = '{0, 24'h000000, 4'd1, 10'd83,  7, "black"};
        vecs[2]  = '{0, 24'hFFFFFF, 4'd5, 10'd70,  7, "white"};
        vecs[3]  = '{0, 24'h712800, 4'd1, 10'd84,  7, "tie_1_3"};
        vecs[4]  = '{0, 24'h321A07, 4'd1, 10'd0,   2, "exact1_early"};
        vecs[5]  = '{0, 24'hAE3F00, 4'd3, 10'd0,   4, "exact3_early"};
        vecs[6]  = '{0, 24'hA08548, 4'd6, 10'd0,   7, "exact6_early"};
        vecs[7]  = '{1, 24'hA08548, 4'd6, 10'd0,   7, "exact6_noearly"};
        vecs[8]  = '{1, 24'hFF4295, 4'd0, 10'd0,   7, "exact0_noearly"};
        vecs[9]  = '{2, 24'hFFFFFF, 4'd0, 10'd295, 3, "white_n3"};
        vecs[10] = '{2, 24'h756332, 4'd1, 10'd183, 3, "entry4_n3"};
        vecs[11] = '{0, 24'hF6F2CE, 4'd5, 10'd1,   7, "near5"};

        repeat (2) @(posedge Clk);
        #1;
        chk("reset_out_valid", 32'(ov[0]), 32'd0);
        chk("reset_out_index", 32'(oi[0]), 32'd0);
        chk("reset_out_dist", 32'(od[0]), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) chk("reset_in_ready", 32'(ir[i]), 32'd1);

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Backpressure: the result must hold while out_ready is low.
        @(negedge Clk);
        iv[0] = 1'b1; rgb[0] = 24'h000000;
        @(posedge Clk);
        #1;
        iv[0] = 1'b0;
        repeat (7) @(posedge Clk);
        #1;
        chk("bp_valid_start", 32'(ov[0]), 32'd1);
        for (int c = 0; c < 10; c++) begin
            @(negedge Clk);
            iv[0] = 1'b1; rgb[0] = 24'hFFFFFF;
            @(posedge Clk);
            #1;
            chk("bp_valid", 32'(ov[0]), 32'd1);
            chk("bp_index", 32'(oi[0]), 32'd1);
            chk("bp_dist", 32'(od[0]), 32'd83);
            chk("bp_in_ready", 32'(ir[0]), 32'd0);
        end
        @(negedge Clk);
        iv[0] = 1'b0; ordy[0] = 1'b1;
        @(posedge Clk);
        #1;
        ordy[0] = 1'b0;
        chk("bp_release_valid", 32'(ov[0]), 32'd0);
        chk("bp_release_ready", 32'(ir[0]), 32'd1);
        @(posedge Clk);
        #1;
        chk("bp_single_transfer", 32'(ov[0]), 32'd0);
        chk("bp_ignored_pixel", 32'(ir[0]), 32'd1);

        // Asynchronous reset during the third search cycle.
        @(negedge Clk);
        iv[0] = 1'b1; rgb[0] = 24'h000000;
        @(posedge Clk);
        #1;
        iv[0] = 1'b0;
        repeat (2) @(posedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        chk("areset_valid", 32'(ov[0]), 32'd0);
        chk("areset_index", 32'(oi[0]), 32'd0);
        chk("areset_dist", 32'(od[0]), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("areset_in_ready", 32'(ir[0]), 32'd1);
        seen_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge Clk);
            #1;
            if (ov[0]) seen_valid = 1'b1;
        end
        chk("areset_no_spurious", 32'(seen_valid), 32'd0);

        fin = '{0, 24'h000000, 4'd1, 10'd83, 7, "post_reset"};
        run_vec(fin);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
